mod_147_sync_timer_bank: RTL and testbench

MOD_147_SYNC_TIMER_BANK -- requirements
Module: mod_147_sync_timer_bank

---
 rtl/mod_147_sync_timer_bank.sv | 96 +++++++++
 tb/tb_mod_147_sync_timer_bank.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_147_sync_timer_bank.sv
// Bank of N_CH independent tick-driven timers with one-shot and auto-reload modes.
// Each channel is a three-state FSM (IDLE/RUN/DONE) with registered done/not_done/expire outputs.
module mod_147_sync_timer_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       periodic,
  input  logic [N_CH*CNT_W-1:0] duration,
  output logic [N_CH-1:0]       timer_done,
  output logic [N_CH-1:0]       timer_not_done,
  output logic [N_CH-1:0]       expire_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             per_q, per_d;
    logic             exp_d;
    logic             done_q, not_done_q, pulse_q;
    logic [CNT_W-1:0] dur_in;
    logic [CNT_W-1:0] dur_eff;

    assign dur_in  = duration[i*CNT_W +: CNT_W];
    // A zero duration behaves as one tick, so the latched copy never holds 0.
    assign dur_eff = (dur_in == '0) ? ONE : dur_in;

    // Priority: stop, then start, then tick-driven counting.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dur_d   = dur_q;
      per_d   = per_q;
      exp_d   = 1'b0;
      if (stop[i]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (start[i]) begin
        state_d = RUN;
        cnt_d   = dur_eff;
        dur_d   = dur_eff;
        per_d   = periodic[i];
      end else if (state_q == RUN && tick) begin
        if (cnt_q > ONE) begin
          cnt_d = cnt_q - ONE;
        end else begin
          exp_d = 1'b1;
          if (per_q) begin
            cnt_d = dur_q;
          end else begin
            state_d = DONE;
          end
        end
      end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        dur_q      <= '0;
        per_q      <= 1'b0;
        done_q     <= 1'b0;
        not_done_q <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        dur_q      <= dur_d;
        per_q      <= per_d;
        done_q     <= (state_d == DONE);
        not_done_q <= (state_d == RUN);
        pulse_q    <= exp_d;
      end
    end

    assign timer_done[i]     = done_q;
    assign timer_not_done[i] = not_done_q;
    assign expire_pulse[i]   = pulse_q;
  end

endmodule

// File: tb/tb_mod_147_sync_timer_bank.sv
// Directed bench for mod_147_sync_timer_bank: one-shot, periodic, gated tick,
// simultaneous events, reset mid-run and staggered multi-channel expiry.
module tb_mod_147_sync_timer_bank;
  localparam int N_CH  = 4;
  localparam int CNT_W = 10;

  logic                  clk;
  logic                  reset;
  logic                  tick;
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH-1:0]       periodic;
  logic [N_CH*CNT_W-1:0] duration;
  logic [N_CH-1:0]       timer_done;
  logic [N_CH-1:0]       timer_not_done;
  logic [N_CH-1:0]       expire_pulse;

  int checks = 0;
  int errors = 0;

  mod_147_sync_timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .start          (start),
    .stop           (stop),
    .periodic       (periodic),
    .duration       (duration),
    .timer_done     (timer_done),
    .timer_not_done (timer_not_done),
    .expire_pulse   (expire_pulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int ch, input int val);
    duration[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic do_reset();
    start    = '0;
    stop     = '0;
    periodic = '0;
    reset    = 1'b1;
    step();
    step();
    reset    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ch(input string tag, input int ch, input logic d, input logic nd, input logic p);
    chk({tag, " done"},     32'(timer_done[ch]),     32'(d));
    chk({tag, " not_done"}, 32'(timer_not_done[ch]), 32'(nd));
    chk({tag, " pulse"},    32'(expire_pulse[ch]),   32'(p));
  endtask

  int exp_edge [N_CH];

  initial begin
    reset    = 1'b1;
    tick     = 1'b0;
    start    = '0;
    stop     = '0;
    periodic = '0;
    duration = '0;
    do_reset();
    chk("reset done",     32'(timer_done),     32'h0);
    chk("reset not_done", 32'(timer_not_done), 32'h0);
    chk("reset pulse",    32'(expire_pulse),   32'h0);

    // one-shot D=5 on ch0
    tick = 1'b1;
    set_dur(0, 5);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk_ch("oneshot e0", 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ch("oneshot run", 0, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_ch("oneshot e5", 0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ch("oneshot hold", 0, 1'b1, 1'b0, 1'b0);
    end
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    chk_ch("oneshot stop", 0, 1'b0, 1'b0, 1'b0);

    // periodic D=3 on ch1, duration change mid-run ignored
    do_reset();
    tick = 1'b1;
    set_dur(1, 3);
    periodic[1] = 1'b1;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    set_dur(1, 7);
    periodic[1] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_ch("periodic", 1, 1'b0, 1'b1, (k % 3) == 0);
    end
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
    chk_ch("periodic stop", 1, 1'b0, 1'b0, 1'b0);

    // gated tick on ch2, D=2, tick present on the start edge is ignored
    do_reset();
    set_dur(2, 2);
    tick = 1'b1;
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick = (e % 4) == 0;
      step();
      chk_ch("gated", 2, e == 8, e < 8, e == 8);
      if (e == 4) begin
        tick = 1'b0;
        for (int k = 0; k < 100; k++) begin
          step();
          chk_ch("frozen", 2, 1'b0, 1'b1, 1'b0);
        end
      end
    end

    // start+stop on same edge while running
    do_reset();
    tick = 1'b1;
    set_dur(3, 4);
    start[3] = 1'b1;
    step();
    chk_ch("ss run", 3, 1'b0, 1'b1, 1'b0);
    stop[3] = 1'b1;
    step();
    start[3] = 1'b0;
    stop[3]  = 1'b0;
    chk_ch("ss idle", 3, 1'b0, 1'b0, 1'b0);

    // restart at cnt==1 coincident with tick: reload, no expiry
    set_dur(0, 3);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    step();
    step();
    set_dur(0, 5);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk_ch("restart", 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_ch("restart run", 0, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_ch("restart exp", 0, 1'b1, 1'b0, 1'b1);

    // D=0 behaves as one tick
    set_dur(1, 0);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    chk_ch("d0 e0", 1, 1'b0, 1'b1, 1'b0);
    step();
    chk_ch("d0 e1", 1, 1'b1, 1'b0, 1'b1);

    // reset mid-run; per-channel stop leaves other channels running
    do_reset();
    tick = 1'b1;
    set_dur(0, 10);
    set_dur(1, 10);
    start = 4'b0011;
    step();
    start = '0;
    step();
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
    chk_ch("stop ch1", 1, 1'b0, 1'b0, 1'b0);
    chk_ch("ch0 unaffected", 0, 1'b0, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst mid done",     32'(timer_done),     32'h0);
    chk("rst mid not_done", 32'(timer_not_done), 32'h0);
    chk("rst mid pulse",    32'(expire_pulse),   32'h0);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("post rst pulse", 32'(expire_pulse), 32'h0);
      chk("post rst done",  32'(timer_done),   32'h0);
    end

    // channel independence with staggered starts
    do_reset();
    tick = 1'b1;
    set_dur(0, 1);
    set_dur(1, 7);
    set_dur(2, 1000);
    set_dur(3, 1023);
    exp_edge[0] = 0 + 1;
    exp_edge[1] = 1 + 7;
    exp_edge[2] = 2 + 1000;
    exp_edge[3] = 3 + 1023;
    for (int e = 0; e <= 1030; e++) begin
      logic [N_CH-1:0] exp_p;
      start = (e < 4) ? (N_CH'(1) << e) : '0;
      step();
      exp_p = '0;
      for (int c = 0; c < N_CH; c++) exp_p[c] = (e == exp_edge[c]);
      chk($sformatf("indep pulse e%0d", e), 32'(expire_pulse), 32'(exp_p));
    end
    chk("indep done",     32'(timer_done),     32'hf);
    chk("indep not_done", 32'(timer_not_done), 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
